ant_draw_multi: RTL and testbench

Draw sequencer for a population of ants, issuing read/plot instructions to the shared datapath over the start_dp/finished_dp handshake. For each of NUM_ANTS ants, it reads x and y from consecutive memory addresses and plots the ant. In erase mode it first repaints each ant's previously drawn pixel in the background colour. It sits between the frame controller (start/finished) and the datapath instruction port.

---
 rtl/ant_draw_multi_if.sv | 13 +
 rtl/ant_draw_multi.sv | 187 ++++++++++++++++++
 tb/tb_ant_draw_multi.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ant_draw_multi_if.sv
// Datapath instruction port: one-cycle instruction strobe out, one-cycle done pulse with read data back.
`timescale 1ns/1ps
interface ant_draw_multi_if #(
  parameter int RESULT_WIDTH = 32
);
  logic                    start_dp;
  logic [31:0]             instruction_dp;
  logic                    finished_dp;
  logic [RESULT_WIDTH-1:0] result_dp;

  modport master (output start_dp, output instruction_dp, input finished_dp, input result_dp);
  modport slave  (input start_dp, input instruction_dp, output finished_dp, output result_dp);
endinterface

// File: rtl/ant_draw_multi.sv
// Draw sequencer: per ant, optionally erases the last drawn pixel, reads x/y from memory, then plots.
`timescale 1ns/1ps
module ant_draw_multi #(
  parameter int NUM_ANTS     = 4,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int ADDR_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    erase_mode,
  input  logic [COLOUR_WIDTH-1:0] ant_colour,
  input  logic [COLOUR_WIDTH-1:0] bg_colour,
  input  logic [ADDR_WIDTH-1:0]   x_base,
  input  logic [ADDR_WIDTH-1:0]   y_base,
  output logic                    finished,
  output logic [7:0]              drawn_count,
  ant_draw_multi_if.master        dp
);

  localparam int IDX_W = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ANTS - 1);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_ERASE_ISSUE = 4'd1;
  localparam logic [3:0] S_ERASE_WAIT  = 4'd2;
  localparam logic [3:0] S_RDX_ISSUE   = 4'd3;
  localparam logic [3:0] S_RDX_WAIT    = 4'd4;
  localparam logic [3:0] S_RDY_ISSUE   = 4'd5;
  localparam logic [3:0] S_RDY_WAIT    = 4'd6;
  localparam logic [3:0] S_PLOT_ISSUE  = 4'd7;
  localparam logic [3:0] S_PLOT_WAIT   = 4'd8;
  localparam logic [3:0] S_NEXT        = 4'd9;

  logic [3:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    erase_q, erase_d;
  logic [COLOUR_WIDTH-1:0] ant_col_q, ant_col_d, bg_col_q, bg_col_d;
  logic [ADDR_WIDTH-1:0]   x_base_q, x_base_d, y_base_q, y_base_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic                    clip_q, clip_d;
  logic [7:0]              drawn_q, drawn_d;
  logic [DEPTH-1:0]        prev_valid_q, prev_valid_d;
  logic [X_WIDTH-1:0]      prev_x_q [DEPTH];
  logic [X_WIDTH-1:0]      prev_x_d [DEPTH];
  logic [Y_WIDTH-1:0]      prev_y_q [DEPTH];
  logic [Y_WIDTH-1:0]      prev_y_d [DEPTH];

  logic                    x_over, y_over;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [X_WIDTH-1:0]      px;
  logic [Y_WIDTH-1:0]      py;
  logic [COLOUR_WIDTH-1:0] pcol;

  assign x_over = (dp.result_dp >> X_WIDTH) != '0;
  assign y_over = (dp.result_dp >> Y_WIDTH) != '0;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    erase_d      = erase_q;
    ant_col_d    = ant_col_q;
    bg_col_d     = bg_col_q;
    x_base_d     = x_base_q;
    y_base_d     = y_base_q;
    x_d          = x_q;
    y_d          = y_q;
    clip_d       = clip_q;
    drawn_d      = drawn_q;
    prev_valid_d = prev_valid_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    case (state_q)
      S_IDLE: if (start) begin
        erase_d   = erase_mode;
        ant_col_d = ant_colour;
        bg_col_d  = bg_colour;
        x_base_d  = x_base;
        y_base_d  = y_base;
        drawn_d   = '0;
        idx_d     = '0;
        state_d   = (erase_mode && prev_valid_q[0]) ? S_ERASE_ISSUE : S_RDX_ISSUE;
      end
      S_ERASE_ISSUE: state_d = S_ERASE_WAIT;
      S_ERASE_WAIT:  if (dp.finished_dp) state_d = S_RDX_ISSUE;
      S_RDX_ISSUE:   state_d = S_RDX_WAIT;
      S_RDX_WAIT: if (dp.finished_dp) begin
        x_d     = X_WIDTH'(dp.result_dp);
        clip_d  = x_over;
        state_d = S_RDY_ISSUE;
      end
      S_RDY_ISSUE:   state_d = S_RDY_WAIT;
      S_RDY_WAIT: if (dp.finished_dp) begin
        y_d = Y_WIDTH'(dp.result_dp);
        // A clipped ant leaves nothing on screen, so it must not be erased next pass
        if (clip_q || y_over) begin
          prev_valid_d[idx_q] = 1'b0;
          state_d             = S_NEXT;
        end else begin
          state_d = S_PLOT_ISSUE;
        end
      end
      S_PLOT_ISSUE:  state_d = S_PLOT_WAIT;
      S_PLOT_WAIT: if (dp.finished_dp) begin
        prev_x_d[idx_q]     = x_q;
        prev_y_d[idx_q]     = y_q;
        prev_valid_d[idx_q] = 1'b1;
        drawn_d             = drawn_q + 8'd1;
        state_d             = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = (erase_q && prev_valid_q[idx_d]) ? S_ERASE_ISSUE : S_RDX_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      erase_q      <= 1'b0;
      ant_col_q    <= '0;
      bg_col_q     <= '0;
      x_base_q     <= '0;
      y_base_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      clip_q       <= 1'b0;
      drawn_q      <= '0;
      prev_valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        prev_x_q[i] <= '0;
        prev_y_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      erase_q      <= erase_d;
      ant_col_q    <= ant_col_d;
      bg_col_q     <= bg_col_d;
      x_base_q     <= x_base_d;
      y_base_q     <= y_base_d;
      x_q          <= x_d;
      y_q          <= y_d;
      clip_q       <= clip_d;
      drawn_q      <= drawn_d;
      prev_valid_q <= prev_valid_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
    end
  end

  always_comb begin
    rd_addr = (state_q == S_RDX_ISSUE) ? x_base_q + ADDR_WIDTH'(idx_q)
                                       : y_base_q + ADDR_WIDTH'(idx_q);
    px   = (state_q == S_ERASE_ISSUE) ? prev_x_q[idx_q] : x_q;
    py   = (state_q == S_ERASE_ISSUE) ? prev_y_q[idx_q] : y_q;
    pcol = (state_q == S_ERASE_ISSUE) ? bg_col_q : ant_col_q;
    dp.start_dp       = 1'b0;
    dp.instruction_dp = '0;
    case (state_q)
      S_ERASE_ISSUE, S_PLOT_ISSUE: begin
        dp.start_dp       = 1'b1;
        dp.instruction_dp = {4'd1, 9'd0, 1'b1, 3'(pcol), 7'(py), 8'(px)};
      end
      S_RDX_ISSUE, S_RDY_ISSUE: begin
        dp.start_dp       = 1'b1;
        dp.instruction_dp = {4'd2, 12'd0, 16'(rd_addr)};
      end
      default: ;
    endcase
    finished    = (state_q == S_IDLE);
    drawn_count = drawn_q;
  end

endmodule

// File: tb/tb_ant_draw_multi.sv
// Directed bench for ant_draw_multi with a latency-programmable datapath responder.
`timescale 1ns/1ps
module tb_ant_draw_multi;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        erase_mode = 1'b0;
  logic [2:0]  ant_colour = '0;
  logic [2:0]  bg_colour = '0;
  logic [15:0] x_base = '0;
  logic [15:0] y_base = '0;
  logic        finished;
  logic [7:0]  drawn_count;

  ant_draw_multi_if #(.RESULT_WIDTH(32)) dp ();

  ant_draw_multi #(
    .NUM_ANTS(2), .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(3), .ADDR_WIDTH(16), .RESULT_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .erase_mode(erase_mode),
    .ant_colour(ant_colour), .bg_colour(bg_colour), .x_base(x_base), .y_base(y_base),
    .finished(finished), .drawn_count(drawn_count), .dp(dp)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:65535];
  logic [31:0] log_q [$];
  int   lat = 3;
  bit   spurious = 1'b0;

  // Datapath model: answers each instruction exactly lat cycles after its strobe.
  initial begin : responder
    bit          pending;
    bit          prev_sd;
    int          cnt;
    logic [31:0] cur_res;
    pending = 1'b0; prev_sd = 1'b0; cnt = 0; cur_res = '0;
    dp.finished_dp = 1'b0;
    dp.result_dp   = '0;
    forever begin
      @(posedge clock); #1;
      dp.finished_dp = 1'b0;
      dp.result_dp   = '0;
      if (reset) begin
        pending = 1'b0;
        prev_sd = 1'b0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            pending        = 1'b0;
            dp.finished_dp = 1'b1;
            dp.result_dp   = cur_res;
          end
        end
        if (dp.start_dp) begin
          checks++;
          if (pending || prev_sd) begin
            errors++;
            $display("FAIL dp_protocol: overlapping/consecutive start_dp, instr=%h pending=%0b prev=%0b",
                     dp.instruction_dp, pending, prev_sd);
          end
          log_q.push_back(dp.instruction_dp);
          cur_res = (dp.instruction_dp[31:28] == 4'd2) ? mem[dp.instruction_dp[15:0]] : 32'd0;
          pending = 1'b1;
          cnt     = lat;
          if (spurious) dp.finished_dp = 1'b1;
        end
        prev_sd = dp.start_dp;
      end
    end
  end

  task automatic run_pass(input bit em, input logic [2:0] ac, input logic [2:0] bg,
                          input logic [15:0] xb, input logic [15:0] yb, input bit poke,
                          output int cyc);
    log_q.delete();
    @(posedge clock); #1;
    erase_mode = em; ant_colour = ac; bg_colour = bg; x_base = xb; y_base = yb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (finished !== 1'b1 && cyc < 400) begin
      if (poke && cyc == 4) begin
        start = 1'b1; erase_mode = ~em; x_base = 16'h1234; ant_colour = 3'b111;
      end else if (poke && cyc == 5) begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 400) begin
      checks++; errors++;
      $display("FAIL pass_timeout: finished still %b after %0d cycles, required 1", finished, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL reset_finished: got %b expected 1", finished); end
    checks++; if (dp.start_dp !== 1'b0) begin errors++; $display("FAIL reset_start_dp: got %b expected 0", dp.start_dp); end
    checks++; if (dp.instruction_dp !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", dp.instruction_dp); end
    checks++; if (drawn_count !== 8'd0) begin errors++; $display("FAIL reset_drawn: got %0d expected 0", drawn_count); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_pass();
    logic [31:0] exp_s [6];
    int cyc;
    exp_s = '{32'h20000010, 32'h20000020, 32'h10050705, 32'h20000011, 32'h20000021, 32'h10050109};
    lat = 3;
    mem[16'h0010] = 32'd5; mem[16'h0011] = 32'd9; mem[16'h0020] = 32'd7; mem[16'h0021] = 32'd1;
    run_pass(1'b0, 3'b010, 3'b000, 16'h0010, 16'h0020, 1'b1, cyc);
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL basic_len: got %0d expected 6", log_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_s[i]) begin
        errors++; $display("FAIL basic_instr[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_s[i]);
      end
    end
    checks++; if (cyc != 27) begin errors++; $display("FAIL basic_latency: got %0d expected 27", cyc); end
    checks++; if (drawn_count !== 8'd2) begin errors++; $display("FAIL basic_drawn: got %0d expected 2", drawn_count); end
    repeat (3) @(posedge clock); #1;
    checks++; if (drawn_count !== 8'd2 || finished !== 1'b1) begin
      errors++; $display("FAIL basic_idle_stable: drawn %0d finished %b expected 2/1", drawn_count, finished);
    end
  endtask

  task automatic test_erase_pass();
    logic [31:0] exp_s [8];
    int cyc;
    exp_s = '{32'h10040705, 32'h20000010, 32'h20000020, 32'h10050706,
              32'h10040109, 32'h20000011, 32'h20000021, 32'h10050209};
    mem[16'h0010] = 32'd6; mem[16'h0011] = 32'd9; mem[16'h0020] = 32'd7; mem[16'h0021] = 32'd2;
    run_pass(1'b1, 3'b010, 3'b000, 16'h0010, 16'h0020, 1'b0, cyc);
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL erase_len: got %0d expected 8", log_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_s[i]) begin
        errors++; $display("FAIL erase_instr[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_s[i]);
      end
    end
    checks++; if (cyc != 35) begin errors++; $display("FAIL erase_latency: got %0d expected 35", cyc); end
    checks++; if (drawn_count !== 8'd2) begin errors++; $display("FAIL erase_drawn: got %0d expected 2", drawn_count); end
  endtask

  task automatic test_clip();
    logic [31:0] exp_a [7];
    logic [31:0] exp_b [7];
    int cyc;
    exp_a = '{32'h10040706, 32'h20000010, 32'h20000020, 32'h10040209, 32'h20000011, 32'h20000021, 32'h10050209};
    exp_b = '{32'h20000010, 32'h20000020, 32'h10050705, 32'h10040209, 32'h20000011, 32'h20000021, 32'h10050209};
    mem[16'h0010] = 32'h00000100;
    run_pass(1'b1, 3'b010, 3'b000, 16'h0010, 16'h0020, 1'b0, cyc);
    checks++; if (log_q.size() != 7) begin errors++; $display("FAIL clip_len: got %0d expected 7", log_q.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_a[i]) begin
        errors++; $display("FAIL clip_instr[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_a[i]);
      end
    end
    checks++; if (cyc != 31) begin errors++; $display("FAIL clip_latency: got %0d expected 31", cyc); end
    checks++; if (drawn_count !== 8'd1) begin errors++; $display("FAIL clip_drawn: got %0d expected 1", drawn_count); end
    mem[16'h0010] = 32'd5;
    run_pass(1'b1, 3'b010, 3'b000, 16'h0010, 16'h0020, 1'b0, cyc);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL postclip_instr[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_b[i]);
      end
    end
    checks++; if (drawn_count !== 8'd2) begin errors++; $display("FAIL postclip_drawn: got %0d expected 2", drawn_count); end
  endtask

  task automatic test_reset_mid_pass();
    logic [31:0] exp_s [6];
    int cyc;
    int guard;
    exp_s = '{32'h20000010, 32'h20000020, 32'h10050705, 32'h20000011, 32'h20000021, 32'h10050209};
    log_q.delete();
    @(posedge clock); #1;
    erase_mode = 1'b1; ant_colour = 3'b010; bg_colour = 3'b000; x_base = 16'h0010; y_base = 16'h0020;
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    guard = 0;
    while (log_q.size() < 3 && guard < 100) begin
      @(posedge clock); #2;
      guard++;
    end
    checks++; if (guard >= 100) begin errors++; $display("FAIL midpass_wait: saw %0d instrs, expected 3", log_q.size()); end
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL midreset_finished: got %b expected 1", finished); end
    checks++; if (dp.start_dp !== 1'b0) begin errors++; $display("FAIL midreset_start_dp: got %b expected 0", dp.start_dp); end
    checks++; if (dp.instruction_dp !== 32'd0) begin errors++; $display("FAIL midreset_instr: got %h expected 0", dp.instruction_dp); end
    checks++; if (drawn_count !== 8'd0) begin errors++; $display("FAIL midreset_drawn: got %0d expected 0", drawn_count); end
    @(posedge clock); #2;
    reset = 1'b0;
    run_pass(1'b1, 3'b010, 3'b000, 16'h0010, 16'h0020, 1'b0, cyc);
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL noerase_len: got %0d expected 6", log_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_s[i]) begin
        errors++; $display("FAIL noerase_instr[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_s[i]);
      end
    end
    checks++; if (cyc != 27) begin errors++; $display("FAIL noerase_latency: got %0d expected 27", cyc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_s [6];
    int cyc;
    exp_s = '{32'h2000FFFF, 32'h20000030, 32'h10050403, 32'h20000000, 32'h20000031, 32'h10050508};
    mem[16'hFFFF] = 32'd3; mem[16'h0030] = 32'd4; mem[16'h0000] = 32'd8; mem[16'h0031] = 32'd5;
    lat = 1;
    spurious = 1'b1;
    run_pass(1'b0, 3'b010, 3'b000, 16'hFFFF, 16'h0030, 1'b0, cyc);
    spurious = 1'b0;
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL b2b_len: got %0d expected 6", log_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_s[i]) begin
        errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_s[i]);
      end
    end
    checks++; if (cyc != 15) begin errors++; $display("FAIL b2b_latency: got %0d expected 15", cyc); end
    checks++; if (drawn_count !== 8'd2) begin errors++; $display("FAIL b2b_drawn: got %0d expected 2", drawn_count); end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_erase_pass();
    test_clip();
    test_reset_mid_pass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
